miai_1bit_alu: RTL and testbench



---
 rtl/miai_1bit_alu.sv | 120 ++++++++++++
 tb/tb_miai_1bit_alu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/miai_1bit_alu.sv
// miai_1bit_alu: bit-serial 1-bit ALU for the TinyTapeout user-project wrapper.
// One strobed cycle computes one result bit of an 8-op function of A, B and a carry
// in. A carry register supports multi-bit serial chaining. An 8-bit result
// history is shown on the bidirectional pins.
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   ena     - design selected; state updates only when high
//   ui_in   - [0]=A [1]=B [2]=ext cin [5:3]=op [6]=use stored carry [7]=strobe
//   uo_out  - {cnt, hist zero, hist parity, valid, carry, result}
//   uio_in  - unused
//   uio_out - result history shift register
//   uio_oe  - constant all-ones (uio pins are outputs)
module miai_1bit_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpXor  = 3'b010,
    OpNot  = 3'b011,
    OpAdd  = 3'b100,
    OpSub  = 3'b101,
    OpNand = 3'b110,
    OpNor  = 3'b111
  } alu_op_e;

  logic       a, b, cin, strobe, upd;
  alu_op_e    op;
  logic [1:0] sum;
  logic       r, co;

  logic       res_q, res_d;
  logic       carry_q, carry_d;
  logic       valid_q, valid_d;
  logic [7:0] hist_q, hist_d;
  logic [2:0] cnt_q, cnt_d;

  // Input pins are consumed by design; uio_in is intentionally ignored.
  logic unused_uio;
  assign unused_uio = ^uio_in;

  assign a      = ui_in[0];
  assign b      = ui_in[1];
  assign op     = alu_op_e'(ui_in[5:3]);
  assign strobe = ui_in[7];
  assign cin    = ui_in[6] ? carry_q : ui_in[2];
  assign upd    = ena & strobe;

  always_comb begin
    sum = 2'b00;
    r   = 1'b0;
    co  = 1'b0;
    unique case (op)
      OpAnd:  r = a & b;
      OpOr:   r = a | b;
      OpXor:  r = a ^ b;
      OpNot:  r = ~a;
      OpAdd: begin
        sum = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        {co, r} = sum;
      end
      // Subtract as A + ~B + cin: cin=1 means no borrow in, co=0 means borrow out.
      OpSub: begin
        sum = {1'b0, a} + {1'b0, ~b} + {1'b0, cin};
        {co, r} = sum;
      end
      OpNand: r = ~(a & b);
      OpNor:  r = ~(a | b);
      default: begin
        r  = 1'b0;
        co = 1'b0;
      end
    endcase
  end

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    valid_d = upd;
    if (upd) begin
      res_d   = r;
      carry_d = co;
      hist_d  = {hist_q[6:0], r};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      hist_q  <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
    end
  end

  assign uo_out  = {cnt_q, ~|hist_q, ^hist_q, valid_q, carry_q, res_q};
  assign uio_out = hist_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_miai_1bit_alu.sv
// Directed self-checking bench for miai_1bit_alu.
module tb_miai_1bit_alu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;

  miai_1bit_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one vector for a single rising edge, then return 1 time unit after it.
  task automatic step(input logic [7:0] v);
    @(negedge clk);
    ui_in = v;
    @(posedge clk);
    #1;
    ui_in = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_uo", uo_out, 8'h10);
    check_eq("rst_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single-bit logic/arith ops from reset: compare {carry, result}.
  typedef struct {
    logic [7:0] v;
    logic [1:0] exp;
    string      tag;
  } vec_t;

  vec_t ops[7];

  initial begin
    ops[0] = '{8'h83, 2'b01, "and11"};
    ops[1] = '{8'h81, 2'b00, "and10"};
    ops[2] = '{8'h8A, 2'b01, "or01"};
    ops[3] = '{8'h98, 2'b01, "not0"};
    ops[4] = '{8'hB3, 2'b00, "nand11"};
    ops[5] = '{8'hB8, 2'b01, "nor00"};
    ops[6] = '{8'hAD, 2'b11, "sub1_0_c1"};

    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h5A;
    #12;
    check_eq("reset_uo", uo_out, 8'h10);
    check_eq("reset_uio", uio_out, 8'h00);
    check_eq("reset_oe", uio_oe, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    step(8'h00);
    step(8'h00);
    check_eq("idle_uo", uo_out, 8'h10);
    check_eq("idle_uio", uio_out, 8'h00);

    // ADD 1+1+0 -> r=0, co=1, cnt=1, valid
    step(8'hA3);
    check_eq("add_uo", uo_out, 8'h36);
    check_eq("add_uio", uio_out, 8'h00);
    step(8'h00);
    check_eq("add_novalid", uo_out, 8'h32);

    // Chained ADD using stored carry: 0+0+1 -> r=1, co=0
    step(8'hE0);
    check_eq("chain_uo", uo_out, 8'h4D);
    check_eq("chain_uio", uio_out, 8'h01);

    // SUB 0-1 with no borrow in -> r=1, borrow out (co=0)
    step(8'hAE);
    check_eq("sub_c1_uo", uo_out, 8'h65);
    check_eq("sub_c1_uio", uio_out, 8'h03);
    // SUB 0-1 with borrow in -> r=0, co=0
    step(8'hAA);
    check_eq("sub_c0_uo", uo_out, 8'h84);
    check_eq("sub_c0_uio", uio_out, 8'h06);

    foreach (ops[i]) begin
      do_reset();
      step(ops[i].v);
      check_eq(ops[i].tag, {6'd0, uo_out[1:0]}, {6'd0, ops[i].exp});
    end

    // History wrap from reset: 8 XOR strobes yielding 1
    do_reset();
    for (int i = 0; i < 8; i++) step(8'h91);
    check_eq("wrap_uio", uio_out, 8'hFF);
    check_eq("wrap_uo", uo_out, 8'h05);
    step(8'h00);
    check_eq("wrap_idle", uo_out, 8'h01);

    // Gating: strobe with ena low changes nothing
    ena = 1'b0;
    step(8'hA3);
    check_eq("gate_uo", uo_out, 8'h01);
    check_eq("gate_uio", uio_out, 8'hFF);
    ena = 1'b1;

    // Mid-chain strobe then asynchronous reset between edges
    step(8'hA3);
    check_eq("mid_uo", uo_out, 8'h2E);
    check_eq("mid_uio", uio_out, 8'hFE);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_uo", uo_out, 8'h10);
    check_eq("async_uio", uio_out, 8'h00);
    check_eq("async_oe", uio_oe, 8'hFF);

    // Reset dominates a coincident strobe
    @(negedge clk);
    ui_in = 8'hA3;
    @(posedge clk);
    #1;
    check_eq("rst_dom_uo", uo_out, 8'h10);
    ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    // Next strobe after reset starts at count 0, carry discarded
    step(8'hE3);
    check_eq("post_rst_uo", uo_out, 8'h36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
